// File: rtl/arith_seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU, 2*WIDTH-bit product split into hi/lo.
// Latency: done pulses WIDTH+2 cycles after start is accepted; one multiply per WIDTH+3 cycles.
// Backpressure: busy is high while an operation runs; start is accepted only in IDLE, never queued.
module arith_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             sign
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;   // multiplicand magnitude
  logic [2*WIDTH-1:0] r_work;    // {partial high word, remaining multiplier bits / low product}
  logic               r_neg;     // final product must be negated
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_zero;
  logic               r_sign;

  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic               w_neg;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_work_neg;
  logic               w_last;

  // Operand magnitudes: the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    w_mag1 = (signed_op && data1[WIDTH-1]) ? (~data1 + {{(WIDTH-1){1'b0}}, 1'b1}) : data1;
    w_mag2 = (signed_op && data2[WIDTH-1]) ? (~data2 + {{(WIDTH-1){1'b0}}, 1'b1}) : data2;
    w_neg  = signed_op & (data1[WIDTH-1] ^ data2[WIDTH-1]);
  end

  // One shift-add iteration: conditional WIDTH+1-bit add, then shift right with carry into the MSB.
  always_comb begin
    w_sum  = {1'b0, r_mcand} + {1'b0, r_work[2*WIDTH-1:WIDTH]};
    w_step = r_work[0] ? {w_sum, r_work[WIDTH-1:1]} : {1'b0, r_work[2*WIDTH-1:1]};
    w_work_neg = ~r_work + {{(2*WIDTH-1){1'b0}}, 1'b1};
    w_last = (r_cnt == CW'(WIDTH - 1));
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_work  <= '0;
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_zero  <= 1'b1;
      r_sign  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start coinciding with a flush is dropped.
          if (start && !cancel) begin
            r_mcand <= w_mag1;
            r_work  <= {{WIDTH{1'b0}}, w_mag2};
            r_neg   <= w_neg;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (cancel) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_work <= w_step;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          r_busy <= 1'b0;
          if (cancel) begin
            r_state <= S_IDLE;
          end else begin
            if (r_neg) begin
              r_work <= w_work_neg;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Commit point: the only place the architectural result changes outside reset.
          r_hi    <= r_work[2*WIDTH-1:WIDTH];
          r_lo    <= r_work[WIDTH-1:0];
          r_zero  <= ~|r_work;
          r_sign  <= r_work[2*WIDTH-1];
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign zero = r_zero;
  assign sign = r_sign;

endmodule

// File: tb/tb_arith_seq_multiplier.sv
module tb_arith_seq_multiplier;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic         cancel = 1'b0;
  logic [W-1:0] data1 = '0;
  logic [W-1:0] data2 = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         zero;
  logic         sign;

  int tests = 0;
  int fails = 0;

  arith_seq_multiplier #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .signed_op(signed_op),
    .cancel(cancel), .data1(data1), .data2(data2), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .zero(zero), .sign(sign)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // Present one start for a single edge; returns at the negedge after acceptance (cycle 0).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clock);
    start = 1'b1; signed_op = s; data1 = a; data2 = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; reports the cycle index it appeared at and busy-cycle count.
  task automatic wait_done(output int lat, output int nbusy);
    lat = -1;
    nbusy = 0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) nbusy++;
      @(negedge clock);
    end
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int lat, nbusy;
    logic [63:0] p;
    p = ref_mul(a, b, s);
    issue(a, b, s);
    wait_done(lat, nbusy);
    chk({tag, "_lat"}, 64'(lat), 64'(W + 2));
    chk({tag, "_nbusy"}, 64'(nbusy), 64'(W + 1));
    chk({tag, "_hi"}, {32'b0, hi}, {32'b0, p[63:32]});
    chk({tag, "_lo"}, {32'b0, lo}, {32'b0, p[31:0]});
    chk({tag, "_zero"}, {63'b0, zero}, {63'b0, (p == 64'd0)});
    chk({tag, "_sign"}, {63'b0, sign}, {63'b0, p[63]});
    @(negedge clock);
    chk({tag, "_pulse"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    int ndone;
    logic [W-1:0] ra, rb;
    logic rs;
    logic [63:0] p;

    // Reset state
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_zero", {63'b0, zero}, 64'd1);
    chk("rst_sign", {63'b0, sign}, 64'd0);

    // Directed products
    full_op("u3x5", 32'd3, 32'd5, 1'b0);

    // Cancel at RUN cycle 10: no done, result keeps 0/15
    issue(32'd7, 32'd9, 1'b0);
    repeat (10) @(negedge clock);
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    chk("cancel_busy", {63'b0, busy}, 64'd0);
    ndone = 0;
    for (int k = 0; k < 50; k++) begin
      if (done) ndone++;
      @(negedge clock);
    end
    chk("cancel_ndone", 64'(ndone), 64'd0);
    chk("cancel_hilo", {hi, lo}, 64'd15);

    full_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    full_op("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1);
    full_op("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
    full_op("s_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    full_op("zero", 32'd0, 32'h1234_5678, 1'b0);
    full_op("s_minx1", 32'h8000_0000, 32'd1, 1'b1);

    // Second start while busy: ignored, exactly one done with the first operands
    issue(32'd11, 32'd13, 1'b0);
    repeat (5) @(negedge clock);
    start = 1'b1; data1 = 32'd1000; data2 = 32'd1000;
    repeat (3) @(negedge clock);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin
        ndone++;
        chk("busy_start_lo", {32'b0, lo}, 64'd143);
      end
      @(negedge clock);
    end
    chk("busy_start_ndone", 64'(ndone), 64'd1);

    // start together with cancel in IDLE is dropped
    @(negedge clock);
    start = 1'b1; cancel = 1'b1; data1 = 32'd2; data2 = 32'd2;
    @(negedge clock);
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel_busy", {63'b0, busy}, 64'd0);

    // Reset mid-operation at RUN cycle 20
    issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    repeat (20) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_zero", {63'b0, zero}, 64'd1);
    full_op("u7x6", 32'd7, 32'd6, 1'b0);
    chk("u7x6_lo42", {32'b0, lo}, 64'd42);

    // Randomized operands, with occasional corner values
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'd0;
        default: ;
      endcase
      full_op($sformatf("rand%0d", i), ra, rb, rs);
    end

    // Results hold in IDLE after the last operation
    p = ref_mul(ra, rb, rs);
    repeat (5) @(negedge clock);
    chk("hold_hilo", {hi, lo}, p);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
